// File: rtl/ps2_device.sv
// Device-side PS/2 link engine: generates the PS/2 clock, sends bytes to the host and
// receives host command frames with ACK. Open-drain lines: drive 0 or release.
//   state    | meaning
//   IDLE     | lines released, waiting for a pending byte or host clock-low
//   TX       | clocking out start, 8 data, odd parity, stop
//   INHIBIT  | host holds clock low; measuring the hold time
//   RTS_WAIT | host requested to send; half-cell pause before clocking
//   RX       | clocking in 8 data, parity, stop
//   RX_ACK   | ACK cell, data driven low
//   GAP      | inter-frame quiet time
module ps2_device #(
  parameter int HALF_PERIOD = 2000,
  parameter int RTS_MIN     = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_err_o,
  output logic       busy_o,
  inout  wire        ps2_clk_io,
  inout  wire        ps2_data_io
);

  localparam int CMAX = (2 * HALF_PERIOD > RTS_MIN) ? 2 * HALF_PERIOD : RTS_MIN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] C_MID  = CW'(HALF_PERIOD / 2);
  localparam logic [CW-1:0] C_GAP  = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] C_RTS  = CW'(RTS_MIN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_INHIBIT, S_RTS_WAIT, S_RX, S_RX_ACK, S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_high;
  logic [3:0]    r_bit;
  logic [9:0]    r_tx_sr;
  logic [7:0]    r_tx_byte;
  logic          r_pend;
  logic [9:0]    r_rx_sr;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_err;
  logic          r_clk_oe;
  logic          r_dat_oe;
  logic          r_clk_m, r_clk_s, r_dat_m, r_dat_s;
  logic          w_cnt_tc;

  assign w_cnt_tc = (r_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_high     <= 1'b0;
      r_bit      <= '0;
      r_tx_sr    <= '0;
      r_tx_byte  <= '0;
      r_pend     <= 1'b0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_clk_m    <= 1'b1;
      r_clk_s    <= 1'b1;
      r_dat_m    <= 1'b1;
      r_dat_s    <= 1'b1;
    end else begin
      r_clk_m    <= ps2_clk_io;
      r_clk_s    <= r_clk_m;
      r_dat_m    <= ps2_data_io;
      r_dat_s    <= r_dat_m;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      // Shared down-counter saturates at zero; states reload it on transitions.
      if (!w_cnt_tc) r_cnt <= r_cnt - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (tx_valid_i && !r_pend) begin
            r_pend    <= 1'b1;
            r_tx_byte <= tx_data_i;
          end
          if (!r_clk_s) begin
            r_state <= S_INHIBIT;
            r_cnt   <= C_RTS;
          end else if (r_pend && w_cnt_tc) begin
            r_state  <= S_TX;
            r_cnt    <= C_HALF;
            r_high   <= 1'b1;
            r_bit    <= '0;
            r_tx_sr  <= {1'b1, ~^r_tx_byte, r_tx_byte};
            r_dat_oe <= 1'b1;
          end
        end

        S_TX: begin
          if (w_cnt_tc) begin
            if (r_high) begin
              if (!r_clk_s && r_bit <= 4'd9) begin
                r_state  <= S_INHIBIT;
                r_cnt    <= C_RTS;
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
              end else begin
                r_high   <= 1'b0;
                r_clk_oe <= 1'b1;
                r_cnt    <= C_HALF;
              end
            end else if (r_bit == 4'd10) begin
              r_state  <= S_GAP;
              r_cnt    <= C_GAP;
              r_clk_oe <= 1'b0;
              r_dat_oe <= 1'b0;
              r_pend   <= 1'b0;
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_high   <= 1'b1;
              r_clk_oe <= 1'b0;
              r_cnt    <= C_HALF;
              r_dat_oe <= ~r_tx_sr[0];
              r_tx_sr  <= {1'b1, r_tx_sr[9:1]};
            end
          end
        end

        S_INHIBIT: begin
          if (r_clk_s) begin
            r_state <= (w_cnt_tc && !r_dat_s) ? S_RTS_WAIT : S_IDLE;
            r_cnt   <= C_HALF;
          end
        end

        // RTS_WAIT is the high half of the start cell, so RX cells open on a falling edge.
        S_RTS_WAIT: begin
          if (w_cnt_tc) begin
            r_state  <= S_RX;
            r_high   <= 1'b0;
            r_clk_oe <= 1'b1;
            r_cnt    <= C_HALF;
            r_bit    <= '0;
          end
        end

        S_RX: begin
          if (r_high && r_cnt == C_MID) r_rx_sr <= {r_dat_s, r_rx_sr[9:1]};
          if (w_cnt_tc) begin
            if (!r_high) begin
              r_high   <= 1'b1;
              r_clk_oe <= 1'b0;
              r_cnt    <= C_HALF;
            end else if (!r_clk_s) begin
              r_state <= S_INHIBIT;
              r_cnt   <= C_RTS;
            end else begin
              r_state  <= (r_bit == 4'd9) ? S_RX_ACK : S_RX;
              r_dat_oe <= (r_bit == 4'd9);
              r_bit    <= r_bit + 1'b1;
              r_high   <= 1'b0;
              r_clk_oe <= 1'b1;
              r_cnt    <= C_HALF;
            end
          end
        end

        S_RX_ACK: begin
          if (w_cnt_tc) begin
            if (!r_high) begin
              r_high   <= 1'b1;
              r_clk_oe <= 1'b0;
              r_cnt    <= C_HALF;
            end else begin
              r_state  <= S_GAP;
              r_cnt    <= C_GAP;
              r_dat_oe <= 1'b0;
              if ((^r_rx_sr[8:0]) && r_rx_sr[9]) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx_sr[7:0];
              end else begin
                r_rx_err <= 1'b1;
              end
            end
          end
        end

        S_GAP: begin
          if (w_cnt_tc) begin
            r_state <= S_IDLE;
            r_cnt   <= C_HALF;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready_o  = (r_state == S_IDLE) && !r_pend;
  assign busy_o      = (r_state != S_IDLE) || r_pend;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign rx_err_o    = r_rx_err;
  assign ps2_clk_io  = r_clk_oe ? 1'b0 : 1'bz;
  assign ps2_data_io = r_dat_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: passive/active PS/2 host model with pull-ups, frame-level
// reference expectations and immediate-assertion checks.
module tb_ps2_device;
  localparam int HP  = 8;
  localparam int RTS = 40;
  localparam int TCK = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        tx_ready, rx_valid, rx_err, busy;
  wire  [7:0] rx_data;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;
  wire        ps2_clk, ps2_dat;

  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_device #(.HALF_PERIOD(HP), .RTS_MIN(RTS)) dut (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_err_o(rx_err), .busy_o(busy), .ps2_clk_io(ps2_clk), .ps2_data_io(ps2_dat)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_clk = 1'b1;
  logic       dq[$];
  longint     tq[$];
  int         n_valid = 0;
  int         n_err = 0;

  // Falling-edge monitor: records the data line and time of every clock fall.
  always @(negedge clk) begin
    if (prev_clk && ps2_clk === 1'b0) begin
      dq.push_back(ps2_dat);
      tq.push_back($time);
    end
    prev_clk = (ps2_clk !== 1'b0);
    if (rx_valid === 1'b1) n_valid++;
    if (rx_err === 1'b1) n_err++;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = $countones(b);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_falls(input int target, input string tag);
    int i = 0;
    while (dq.size() < target && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_edges"}, 32'(dq.size() >= target), 32'(1));
  endtask

  task automatic send_tx(input logic [7:0] b);
    int i = 0;
    while (tx_ready !== 1'b1 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'(1));
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic check_tx_frame(input logic [7:0] b, input string tag);
    int         base = dq.size();
    int         i = 0;
    logic [10:0] obs;
    wait_falls(base + 11, tag);
    for (int k = 0; k < 11; k++) obs[k] = (dq.size() > base + k) ? dq[base + k] : 1'bx;
    check({tag, "_bits"}, 32'(obs), 32'(frame_of(b)));
    check({tag, "_period"}, 32'(tq[base + 1] - tq[base]), 32'(2 * HP * TCK));
    while (tx_ready !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_ready_back"}, 32'(tx_ready), 32'(1));
    check({tag, "_no_extra"}, 32'(dq.size()), 32'(base + 11));
  endtask

  task automatic host_rts(input logic with_tx, input logic [7:0] txb);
    host_clk_low = 1'b1;
    @(negedge clk);
    if (with_tx) begin
      tx_data  = txb;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("rts_tx_pending_busy", 32'(busy), 32'(1));
    end
    repeat (RTS + 20) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (4) @(negedge clk);
    host_clk_low = 1'b0;
  endtask

  task automatic host_bits(input logic [7:0] b, input logic bad_par, input string tag);
    int         base = dq.size();
    int         v0 = n_valid;
    int         e0 = n_err;
    int         i = 0;
    logic [9:0] fr;
    fr = {1'b1, (($countones(b) % 2) == 0) ^ bad_par, b};
    for (int k = 0; k < 10; k++) begin
      wait_falls(base + k + 1, tag);
      host_dat_low = ~fr[k];
    end
    wait_falls(base + 11, tag);
    check({tag, "_ack_low"}, 32'(ps2_dat), 32'(0));
    while ((n_valid + n_err) == (v0 + e0) && i < 6 * HP) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    if (!bad_par) last_good = b;
    check({tag, "_valid_pulses"}, 32'(n_valid - v0), 32'(!bad_par));
    check({tag, "_err_pulses"}, 32'(n_err - e0), 32'(bad_par));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(last_good));
    check({tag, "_ack_released"}, 32'(ps2_dat), 32'(1));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rbad;
    int         base;
    int         i;

    repeat (4) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_rx_err", 32'(rx_err), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_clk_line", 32'(ps2_clk), 32'(1));
    check("rst_dat_line", 32'(ps2_dat), 32'(1));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_tx(8'h1C);
    check("tx_busy_pending", 32'(busy), 32'(1));
    check_tx_frame(8'h1C, "tx_1c");
    for (int n = 0; n < 3; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_tx(rb);
      check_tx_frame(rb, "tx_rand");
    end

    repeat (10) @(negedge clk);
    host_rts(1'b0, 8'h00);
    host_bits(8'hED, 1'b0, "rx_ed");
    repeat (10) @(negedge clk);
    host_rts(1'b0, 8'h00);
    host_bits(8'hED ^ 8'h5A, 1'b1, "rx_badpar");
    for (int n = 0; n < 4; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rbad = 1'($urandom_range(0, 1));
      repeat (10) @(negedge clk);
      host_rts(1'b0, 8'h00);
      host_bits(rb, rbad, "rx_rand");
    end

    // Host inhibit during data bit 3 of 0xAA, shorter than an RTS.
    send_tx(8'hAA);
    base = dq.size();
    wait_falls(base + 4, "abort_pre");
    i = 0;
    while (ps2_clk !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    host_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_dat_released", 32'(ps2_dat), 32'(1));
    check("abort_still_busy", 32'(busy), 32'(1));
    check("abort_not_ready", 32'(tx_ready), 32'(0));
    host_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_clk_released", 32'(ps2_clk), 32'(1));
    check_tx_frame(8'hAA, "tx_aa_retry");

    repeat (10) @(negedge clk);
    host_rts(1'b1, 8'h55);
    rb = 8'($urandom_range(0, 255));
    host_bits(rb, 1'b0, "rx_priority");
    check("rx_priority_tx_pending", 32'(busy), 32'(1));
    check_tx_frame(8'h55, "tx_55_after_rx");

    send_tx(8'h3C);
    base = dq.size();
    wait_falls(base + 3, "reset_pre");
    repeat (HP / 2 + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_line", 32'(ps2_clk), 32'(1));
    check("midrst_dat_line", 32'(ps2_dat), 32'(1));
    check("midrst_tx_ready", 32'(tx_ready), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = dq.size();
    repeat (200) @(negedge clk);
    check("midrst_no_edges", 32'(dq.size()), 32'(base));
    check("midrst_idle_busy", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
